pipeline_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 31 +++
 rtl/div_pacer.sv | 55 +++++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stage indices, sequencer states and the enable-pattern helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    DIV_BUSY,
    DIV_DONE,
    FETCH_DRAIN
  } state_t;

  localparam int STG_NONE  = 0;
  localparam int STG_IF    = 1;
  localparam int STG_ID    = 2;
  localparam int STG_EX    = 3;
  localparam int STG_MEM   = 4;
  localparam int DIV_CNT_W = 6;

  // Enables {pc,if_id,id_ex,ex_mem,mem_wb} for deepest stall smax.
  // Register k runs when k > smax+1; with no stall everything runs.
  function automatic logic [4:0] stall_en(
    input logic [2:0] smax
  );
    return {smax == 3'(STG_NONE),
            smax < 3'(STG_IF),
            smax < 3'(STG_ID),
            smax < 3'(STG_EX),
            smax < 3'(STG_MEM)};
  endfunction

endpackage

// File: rtl/div_pacer.sv
// Divider pacing: countdown plus start/cancel/valid strobes.
// Strobes are combinational and forced low while in reset.
module div_pacer
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t i_state,
  input  logic   i_ex_div_req,
  input  logic   i_stall_mem,
  input  logic   i_exc_acc,
  output logic   o_cnt_last,
  output logic   o_div_start,
  output logic   o_div_cancel,
  output logic   o_div_result_valid
);

  localparam logic [DIV_CNT_W-1:0] LOAD =
    DIV_CNT_W'(DIV_CYCLES - 1);

  logic [DIV_CNT_W-1:0] r_cnt;
  logic                 w_busy;
  logic                 w_done;

  assign w_busy = (i_state == DIV_BUSY);
  assign w_done = (i_state == DIV_DONE);

  assign o_div_start = rst_n & (i_state == RUN)
                     & i_ex_div_req & ~i_stall_mem
                     & ~i_exc_acc;

  assign o_div_cancel = rst_n & i_exc_acc
                      & (w_busy | w_done);

  assign o_div_result_valid = rst_n & w_done;

  // Last busy cycle: the decrement below lands on zero.
  assign o_cnt_last = (r_cnt == DIV_CNT_W'(1));

  // Load on launch, count down while busy, clear on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (o_div_start) begin
      r_cnt <= LOAD;
    end else if (o_div_cancel) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - DIV_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Resolves stall requests into enables, paces div, redirects PC.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        ex_div_req,
  input  logic        mem_stall_req,
  input  logic        exception_req,
  output logic        en_pc,
  output logic        en_if_id,
  output logic        en_id_ex,
  output logic        en_ex_mem,
  output logic        en_mem_wb,
  output logic        flush,
  output logic        pc_redirect,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_result_valid,
  output logic [31:0] stall_cycles
);

  state_t      r_state;
  logic [31:0] r_stall_cycles;
  logic [2:0]  w_smax;
  logic [4:0]  w_en;
  logic        w_stall_ex;
  logic        w_exc_acc;
  logic        w_redirect;
  logic        w_cnt_last;
  logic        w_drain;

  assign w_drain    = (r_state == FETCH_DRAIN);
  assign w_stall_ex = ((r_state == RUN) & ex_div_req)
                    | (r_state == DIV_BUSY);
  assign w_exc_acc  = exception_req & ~mem_stall_req
                    & ~w_drain;

  // Deepest asserted stall wins.
  always_comb begin
    w_smax = 3'(STG_NONE);
    if (mem_stall_req)
      w_smax = 3'(STG_MEM);
    else if (w_stall_ex)
      w_smax = 3'(STG_EX);
    else if (id_stall_req)
      w_smax = 3'(STG_ID);
    else if (if_stall_req)
      w_smax = 3'(STG_IF);
  end

  // Enable pattern, with exception and fetch-drain overrides.
  always_comb begin
    w_en       = stall_en(w_smax);
    w_redirect = 1'b0;
    if (w_exc_acc) begin
      w_en       = {~if_stall_req, 4'b1111};
      w_redirect = ~if_stall_req;
    end else if (w_drain) begin
      w_en[4]    = ~if_stall_req;
      w_en[3]    = 1'b0;
      w_en[2]    = 1'b1;
      w_redirect = ~if_stall_req;
    end
  end

  assign en_pc       = resetn & w_en[4];
  assign en_if_id    = resetn & w_en[3];
  assign en_id_ex    = resetn & w_en[2];
  assign en_ex_mem   = resetn & w_en[1];
  assign en_mem_wb   = resetn & w_en[0];
  assign flush       = resetn & w_exc_acc;
  assign pc_redirect = resetn & w_redirect;

  div_pacer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_pacer (
    .clk               (clk),
    .rst_n             (resetn),
    .i_state           (r_state),
    .i_ex_div_req      (ex_div_req),
    .i_stall_mem       (mem_stall_req),
    .i_exc_acc         (w_exc_acc),
    .o_cnt_last        (w_cnt_last),
    .o_div_start       (div_start),
    .o_div_cancel      (div_cancel),
    .o_div_result_valid(div_result_valid)
  );

  // Sequencer state; an accepted exception overrides everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
    end else if (w_exc_acc) begin
      r_state <= if_stall_req ? FETCH_DRAIN : RUN;
    end else begin
      unique case (r_state)
        RUN:
          if (div_start) r_state <= DIV_BUSY;
        DIV_BUSY:
          if (w_cnt_last) r_state <= DIV_DONE;
        DIV_DONE:
          if (w_en[1]) r_state <= RUN;
        FETCH_DRAIN:
          if (!if_stall_req) r_state <= RUN;
      endcase
    end
  end

  // Count every cycle in which any register is held or bubbled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_stall_cycles <= '0;
    else if (~&w_en)
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl.
// Vector table plus multi-cycle sequences through a scoreboard.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_s, id_s, exd, mem_s, exc;
  logic        en_pc, en_if_id, en_id_ex;
  logic        en_ex_mem, en_mem_wb;
  logic        flush, pc_redirect;
  logic        div_start, div_cancel, div_result_valid;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .if_stall_req    (if_s),
    .id_stall_req    (id_s),
    .ex_div_req      (exd),
    .mem_stall_req   (mem_s),
    .exception_req   (exc),
    .en_pc           (en_pc),
    .en_if_id        (en_if_id),
    .en_id_ex        (en_id_ex),
    .en_ex_mem       (en_ex_mem),
    .en_mem_wb       (en_mem_wb),
    .flush           (flush),
    .pc_redirect     (pc_redirect),
    .div_start       (div_start),
    .div_cancel      (div_cancel),
    .div_result_valid(div_result_valid),
    .stall_cycles    (stall_cycles)
  );

  // inputs: {if, id, ex_div, mem, exc}
  typedef struct packed {
    logic if_s, id_s, exd, mem_s, exc;
  } in_t;

  // outputs: {pc,if_id,id_ex,ex_mem,mem_wb}, fl, rd, ds, dc, dv
  typedef struct packed {
    logic [4:0] en;
    logic fl, rd, ds, dc, dv;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  out_t        q[$];
  vec_t        tbl[11];
  int          checks = 0;
  int          failures = 0;
  int unsigned model_sc = 0;

  function automatic out_t mk(input logic [4:0] en,
                              input logic [4:0] f);
    return out_t'({en, f});
  endfunction

  function automatic vec_t mv(input string nm,
                              input logic [4:0] i,
                              input logic [4:0] en,
                              input logic [4:0] f);
    vec_t v;
    v.nm = nm;
    v.i  = in_t'(i);
    v.o  = mk(en, f);
    return v;
  endfunction

  function automatic out_t got();
    return out_t'({en_pc, en_if_id, en_id_ex, en_ex_mem,
                   en_mem_wb, flush, pc_redirect, div_start,
                   div_cancel, div_result_valid});
  endfunction

  task automatic cmp_out(input string nm, input out_t e);
    out_t g;
    g = got();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: outputs got=%b want=%b", nm, g, e);
    end
  endtask

  task automatic cmp_sc(input string nm);
    checks++;
    if (stall_cycles !== model_sc) begin
      failures++;
      $display("FAIL %s stall_cycles: got=%0d want=%0d",
               nm, stall_cycles, model_sc);
    end
  endtask

  task automatic drive(input in_t i);
    {if_s, id_s, exd, mem_s, exc} = i;
  endtask

  // One cycle: drive, queue expectation, compare at negedge.
  task automatic step(input string nm, input logic [4:0] i,
                      input logic [4:0] en, input logic [4:0] f);
    out_t x;
    drive(in_t'(i));
    q.push_back(mk(en, f));
    @(negedge clk);
    x = q.pop_front();
    cmp_out(nm, x);
    cmp_sc(nm);
    if (x.en != 5'h1f) model_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string nm);
    out_t x;
    q.push_back('0);
    x = q.pop_front();
    model_sc = 0;
    cmp_out(nm, x);
    cmp_sc(nm);
  endtask

  task automatic div_launch();
    step("div_start", 5'b00100, 5'b00001, 5'b00100);
  endtask

  initial begin
    tbl[0]  = mv("id_stall",  5'b01000, 5'b00011, 5'b00000);
    tbl[1]  = mv("idle",      5'b00000, 5'b11111, 5'b00000);
    tbl[2]  = mv("if_stall",  5'b10000, 5'b00111, 5'b00000);
    tbl[3]  = mv("mem_stall", 5'b00010, 5'b00000, 5'b00000);
    tbl[4]  = mv("if_id",     5'b11000, 5'b00011, 5'b00000);
    tbl[5]  = mv("id_mem",    5'b01010, 5'b00000, 5'b00000);
    tbl[6]  = mv("exc_mem",   5'b00011, 5'b00000, 5'b00000);
    tbl[7]  = mv("div_mem",   5'b00110, 5'b00000, 5'b00000);
    tbl[8]  = mv("exc_run",   5'b00001, 5'b11111, 5'b11000);
    tbl[9]  = mv("exc_div",   5'b00101, 5'b11111, 5'b11000);
    tbl[10] = mv("idle2",     5'b00000, 5'b11111, 5'b00000);

    drive(in_t'(5'b11111));
    #3;
    check_reset("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int n = 0; n < 11; n++)
      step(tbl[n].nm, tbl[n].i, tbl[n].o.en,
           {tbl[n].o.fl, tbl[n].o.rd, tbl[n].o.ds,
            tbl[n].o.dc, tbl[n].o.dv});

    for (int n = 0; n < 3; n++)
      step("mem_if", 5'b10010, 5'b00000, 5'b00000);
    step("mem_if_after", 5'b00000, 5'b11111, 5'b00000);

    div_launch();
    for (int k = 1; k <= 31; k++)
      step("div_busy", 5'b00100, 5'b00001, 5'b00000);
    step("div_done", 5'b00100, 5'b11111, 5'b00001);
    step("div_run", 5'b00000, 5'b11111, 5'b00000);

    div_launch();
    for (int k = 1; k <= 31; k++) begin
      if (k == 3)
        step("busy_mem", 5'b00110, 5'b00000, 5'b00000);
      else
        step("div_busy2", 5'b00100, 5'b00001, 5'b00000);
    end
    step("done_mem1", 5'b00110, 5'b00000, 5'b00001);
    step("done_mem2", 5'b00110, 5'b00000, 5'b00001);
    step("done_go", 5'b00100, 5'b11111, 5'b00001);
    step("done_run", 5'b00000, 5'b11111, 5'b00000);

    div_launch();
    for (int k = 1; k <= 9; k++)
      step("div_busy3", 5'b00100, 5'b00001, 5'b00000);
    step("exc_busy", 5'b00101, 5'b11111, 5'b11010);
    step("exc_busy_run", 5'b00000, 5'b11111, 5'b00000);

    step("exc_ifs", 5'b10001, 5'b01111, 5'b10000);
    step("drain_exc", 5'b10001, 5'b00111, 5'b00000);
    step("drain", 5'b10000, 5'b00111, 5'b00000);
    step("drain", 5'b10000, 5'b00111, 5'b00000);
    step("drain_end", 5'b00000, 5'b10111, 5'b01000);
    step("drain_run", 5'b00000, 5'b11111, 5'b00000);

    div_launch();
    for (int k = 1; k <= 4; k++)
      step("div_busy4", 5'b00100, 5'b00001, 5'b00000);
    drive(in_t'(5'b00100));
    #2;
    resetn = 1'b0;
    #1;
    check_reset("reset_mid_div");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step("rst_restart", 5'b00100, 5'b00001, 5'b00100);
    step("rst_busy", 5'b00100, 5'b00001, 5'b00000);
    step("rst_cancel", 5'b00101, 5'b11111, 5'b11010);
    step("final_idle", 5'b00000, 5'b11111, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
